// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the register-write request type for the write-back merge stage.
package wb_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_merge_if.sv
// wb_merge_if: pipeline/mul-div producer inputs and register-file write port of the merge stage.
interface wb_merge_if;
    import wb_pkg::*;
    logic                  pipe_we_i;
    logic [ADDR_W-1:0]     pipe_rd_i;
    logic [DATA_W-1:0]     pipe_data_i;
    logic                  md_valid_i;
    logic                  md_ready_o;
    logic [ADDR_W-1:0]     md_rd_i;
    logic [DATA_W-1:0]     md_data_i;
    logic                  RegWrite_o;
    logic [ADDR_W-1:0]     RDaddr_o;
    logic [DATA_W-1:0]     RDdata_o;
    logic [2**ADDR_W-1:0]  pend_o;
    logic                  busy_o;
    modport master(
        output pipe_we_i, pipe_rd_i, pipe_data_i, md_valid_i, md_rd_i, md_data_i,
        input  md_ready_o, RegWrite_o, RDaddr_o, RDdata_o, pend_o, busy_o
    );
    modport slave(
        input  pipe_we_i, pipe_rd_i, pipe_data_i, md_valid_i, md_rd_i, md_data_i,
        output md_ready_o, RegWrite_o, RDaddr_o, RDdata_o, pend_o, busy_o
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: compacting mul/div result buffer; valid entries always occupy slots 0..count-1,
// so squash-by-address and pop simply re-pack the survivors before the push is appended.
module wb_fifo import wb_pkg::*; #(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  wb_req_t              i_push_req,
    input  logic                 i_pop,
    input  logic                 i_sq,
    input  logic [ADDR_W-1:0]    i_sq_rd,
    output wb_req_t              o_head,
    output logic [CNT_W-1:0]     o_count,
    output logic [2**ADDR_W-1:0] o_pend
);
    logic [DEPTH-1:0] r_vld, w_n_vld;
    wb_req_t          r_ent   [DEPTH];
    wb_req_t          w_n_ent [DEPTH];
    logic [2**ADDR_W-1:0] w_pend;

    always_comb begin
        int n;
        n = 0;
        w_n_vld = '0;
        w_n_ent = r_ent;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && !(i_sq && r_ent[i].rd == i_sq_rd) && !(i_pop && i == 0)) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == n) begin
                        w_n_ent[j] = r_ent[i];
                        w_n_vld[j] = 1'b1;
                    end
                end
                n++;
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (i_push && j == n) begin
                w_n_ent[j] = i_push_req;
                w_n_vld[j] = 1'b1;
            end
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) w_pend[r_ent[i].rd] = 1'b1;
        end
        w_pend[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_ent <= '{default: '0};
        end else begin
            r_vld <= w_n_vld;
            r_ent <= w_n_ent;
        end
    end

    assign o_head  = r_ent[0];
    assign o_count = CNT_W'($countones(r_vld));
    assign o_pend  = w_pend;
endmodule

// File: rtl/wb_merge.sv
// wb_merge: register-file write-port arbiter; pipeline write-back has absolute priority,
// mul/div results bypass when possible and are buffered otherwise.
module wb_merge import wb_pkg::*; #(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input logic       clk,
    input logic       rst,
    wb_merge_if.slave bus
);
    logic                 w_pipe, w_acc, w_md_live, w_busy, w_ready, w_push, w_pop, w_issue;
    logic [CNT_W-1:0]     w_count;
    logic [2**ADDR_W-1:0] w_pend;
    wb_req_t              w_head, w_pipe_req, w_md_req, w_out, r_out;
    logic                 r_we;

    assign w_pipe_req = '{rd: bus.pipe_rd_i, data: bus.pipe_data_i};
    assign w_md_req   = '{rd: bus.md_rd_i, data: bus.md_data_i};
    assign w_ready    = w_count < CNT_W'(DEPTH);
    assign w_busy     = w_count != '0;
    assign w_pipe     = bus.pipe_we_i && bus.pipe_rd_i != '0;
    assign w_acc      = bus.md_valid_i && w_ready;
    // x0 results and results overwritten by the younger pipeline write are consumed but never stored
    assign w_md_live  = w_acc && bus.md_rd_i != '0 && !(w_pipe && bus.md_rd_i == bus.pipe_rd_i);
    assign w_pop      = !w_pipe && w_busy;
    assign w_push     = w_md_live && (w_pipe || w_busy);
    assign w_issue    = w_pipe || w_busy || w_md_live;
    assign w_out      = w_pipe ? w_pipe_req : w_busy ? w_head : w_md_req;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_req (w_md_req),
        .i_pop      (w_pop),
        .i_sq       (w_pipe),
        .i_sq_rd    (bus.pipe_rd_i),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_pend     (w_pend)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we  <= 1'b0;
            r_out <= '0;
        end else begin
            r_we <= w_issue;
            if (w_issue) r_out <= w_out;
        end
    end

    assign bus.RegWrite_o = r_we;
    assign bus.RDaddr_o   = r_out.rd;
    assign bus.RDdata_o   = r_out.data;
    assign bus.pend_o     = w_pend;
    assign bus.busy_o     = w_busy;
    assign bus.md_ready_o = w_ready;
endmodule

// File: tb/tb_wb_merge.sv
// tb_wb_merge: scenario tasks drive the merge stage; expected register writes go into a
// scoreboard queue in issue order and a negedge monitor pops and compares every write.
module tb_wb_merge;
    import wb_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    wb_req_t exp_q[$];

    wb_merge_if bus();
    wb_merge #(.DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.RegWrite_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected got rd=%0d data=%h, required no write", bus.RDaddr_o, bus.RDdata_o);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                if (bus.RDaddr_o !== e.rd || bus.RDdata_o !== e.data) begin
                    errors++;
                    $display("FAIL wr_order got rd=%0d data=%h, required rd=%0d data=%h", bus.RDaddr_o, bus.RDdata_o, e.rd, e.data);
                end
            end
        end
    end

    task automatic drive(input logic pwe, input logic [ADDR_W-1:0] prd, input logic [DATA_W-1:0] pd,
                         input logic mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md);
        bus.pipe_we_i = pwe;
        bus.pipe_rd_i = prd;
        bus.pipe_data_i = pd;
        bus.md_valid_i = mv;
        bus.md_rd_i = mrd;
        bus.md_data_i = md;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
        exp_q.push_back('{rd: rd, data: data});
    endtask

    task automatic settle;
        drive(0, 0, 0, 0, 0, 0);
        tick;
        tick;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o, bus.pend_o, bus.busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_outs got we=%b addr=%0d data=%h pend=%h busy=%b, required all 0",
                     bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o, bus.pend_o, bus.busy_o);
        end
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.md_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b, required 1", bus.md_ready_o);
        end
    endtask

    task automatic test_pipe;
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        expect_wr(5, 32'hDEADBEEF);
        tick;
        checks++;
        if (bus.RegWrite_o !== 1'b1 || bus.RDaddr_o !== 5'd5 || bus.RDdata_o !== 32'hDEADBEEF || bus.pend_o !== '0) begin
            errors++;
            $display("FAIL pipe_write got we=%b addr=%0d data=%h pend=%h, required 1/5/deadbeef/0",
                     bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o, bus.pend_o);
        end
        settle;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pipe_drain got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bypass;
        drive(0, 0, 0, 1, 7, 42);
        expect_wr(7, 42);
        tick;
        checks++;
        if (bus.RegWrite_o !== 1'b1 || bus.RDaddr_o !== 5'd7 || bus.pend_o[7] !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL bypass got we=%b addr=%0d pend7=%b busy=%b, required 1/7/0/0",
                     bus.RegWrite_o, bus.RDaddr_o, bus.pend_o[7], bus.busy_o);
        end
        settle;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bypass_drain got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back;
        drive(1, 10, 100, 1, 3, 30);
        expect_wr(10, 100);
        tick;
        checks++;
        if (bus.pend_o !== 32'h8 || bus.md_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_one got pend=%h ready=%b, required 8/1", bus.pend_o, bus.md_ready_o);
        end
        drive(1, 11, 101, 1, 4, 40);
        expect_wr(11, 101);
        tick;
        checks++;
        if (bus.pend_o !== 32'h18 || bus.md_ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_full got pend=%h ready=%b busy=%b, required 18/0/1", bus.pend_o, bus.md_ready_o, bus.busy_o);
        end
        drive(1, 12, 102, 0, 0, 0);
        expect_wr(12, 102);
        tick;
        checks++;
        if (bus.md_ready_o !== 1'b0 || bus.pend_o !== 32'h18) begin
            errors++;
            $display("FAIL b2b_hold got ready=%b pend=%h, required 0/18", bus.md_ready_o, bus.pend_o);
        end
        drive(0, 0, 0, 0, 0, 0);
        expect_wr(3, 30);
        tick;
        checks++;
        if (bus.md_ready_o !== 1'b1 || bus.pend_o !== 32'h10) begin
            errors++;
            $display("FAIL b2b_pop got ready=%b pend=%h, required 1/10", bus.md_ready_o, bus.pend_o);
        end
        expect_wr(4, 40);
        tick;
        checks++;
        if (bus.pend_o !== '0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty got pend=%h busy=%b, required 0/0", bus.pend_o, bus.busy_o);
        end
        settle;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_squash;
        drive(1, 20, 5, 1, 9, 99);
        expect_wr(20, 5);
        tick;
        checks++;
        if (bus.pend_o !== 32'h200) begin
            errors++;
            $display("FAIL squash_buf got pend=%h, required 200", bus.pend_o);
        end
        drive(1, 9, 1, 0, 0, 0);
        expect_wr(9, 1);
        tick;
        checks++;
        if (bus.pend_o !== '0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL squash_clear got pend=%h busy=%b, required 0/0", bus.pend_o, bus.busy_o);
        end
        drive(1, 8, 2, 1, 8, 77);
        expect_wr(8, 2);
        tick;
        checks++;
        if (bus.pend_o !== '0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL squash_same got pend=%h busy=%b, required 0/0", bus.pend_o, bus.busy_o);
        end
        settle;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL squash_drain got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_x0;
        drive(1, 0, 32'h55, 1, 0, 32'h66);
        tick;
        checks++;
        if (bus.RegWrite_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL x0_both got we=%b busy=%b, required 0/0", bus.RegWrite_o, bus.busy_o);
        end
        drive(1, 0, 32'h55, 1, 6, 66);
        expect_wr(6, 66);
        tick;
        checks++;
        if (bus.RegWrite_o !== 1'b1 || bus.RDaddr_o !== 5'd6 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL x0_bypass got we=%b addr=%0d busy=%b, required 1/6/0", bus.RegWrite_o, bus.RDaddr_o, bus.busy_o);
        end
        settle;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL x0_drain got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_rst_mid;
        drive(1, 21, 1, 1, 2, 22);
        expect_wr(21, 1);
        tick;
        drive(1, 22, 2, 1, 3, 33);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o, bus.pend_o, bus.busy_o} !== '0) begin
            errors++;
            $display("FAIL rst_mid got we=%b addr=%0d data=%h pend=%h busy=%b, required all 0",
                     bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o, bus.pend_o, bus.busy_o);
        end
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.md_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_release got ready=%b busy=%b, required 1/0", bus.md_ready_o, bus.busy_o);
        end
        settle;
        tick;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_drain got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset;
        test_pipe;
        test_bypass;
        test_back_to_back;
        test_squash;
        test_x0;
        test_rst_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
